// File: rtl/neurosync_play_unit.sv
// ---------------------------------------------------------------------------
// neurosync_play_unit
//
// Sequence player and response checker for the NeuroSync game. The game
// controller loads a question's note sequence with set_pos; the unit plays
// each note on the buzzer and then grades the player's button presses
// against the sequence. It also plays a short confirmation tone on request.
//
// Parameters:
//   SEQ_LEN        notes per question sequence
//   NOTE_CYCLES    cycles each note is sounded
//   GAP_CYCLES     silent cycles after each note
//   CONFIRM_CYCLES length of the confirmation tone
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous active-high reset to IDLE
//   zera            synchronous clear to IDLE
//   set_pos         pulse: latch seq_data and start playback
//   seq_data        packed sequence, note i in bits [2i+1:2i]
//   jogando         presses are graded only while high
//   botoes          edge-detected button pulses, bit k = note k
//   tocar_confirma  pulse: play the confirmation tone
//   pronto_play     unit idle or waiting for the player's answer
//   acertou_play    whole sequence answered correctly
//   errou           one-cycle pulse on a wrong press
//   tom_ativo       buzzer enable
//   nota            note being sounded (0 while silent)
// ---------------------------------------------------------------------------
module neurosync_play_unit #(
   parameter int SEQ_LEN        = 4,
   parameter int NOTE_CYCLES    = 50000,
   parameter int GAP_CYCLES     = 10000,
   parameter int CONFIRM_CYCLES = 25000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   zera,
   input  logic                   set_pos,
   input  logic [2*SEQ_LEN-1:0]   seq_data,
   input  logic                   jogando,
   input  logic [3:0]             botoes,
   input  logic                   tocar_confirma,
   output logic                   pronto_play,
   output logic                   acertou_play,
   output logic                   errou,
   output logic                   tom_ativo,
   output logic [1:0]             nota
);

   // The single counter times notes, gaps and the confirmation tone, so it
   // is sized for the largest of the three durations.
   localparam int MAX_NG  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int MAX_CYC = (MAX_NG > CONFIRM_CYCLES) ? MAX_NG : CONFIRM_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = $clog2(SEQ_LEN + 1);

   localparam logic [CNT_W-1:0] NOTE_LAST    = CNT_W'(NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(SEQ_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TOCA,
      PAUSA,
      ESPERA_RESP,
      CERTO,
      CONFIRMA
   } state_t;

   state_t                 state;
   logic [2*SEQ_LEN-1:0]   seq_reg;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       idx_next;
   logic [CNT_W-1:0]       cnt;
   logic [1:0]             cur_note;
   logic [1:0]             next_note;
   logic [3:0]             expected_press;
   logic                   confirm_allowed;

   assign idx_next = idx + IDX_W'(1);

   // Note lookup for the current and the following sequence position. A
   // compare-and-select loop keeps the index widths exact and maps to a
   // plain mux.
   always_comb begin
      cur_note  = 2'b00;
      next_note = 2'b00;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_note = seq_reg[2*i +: 2];
         end
         if (idx_next == IDX_W'(i)) begin
            next_note = seq_reg[2*i +: 2];
         end
      end
   end

   // A correct answer is exactly one button, the one matching the note at
   // the current response position; any other pattern is a mistake.
   assign expected_press = 4'b0001 << cur_note;

   // The confirmation tone may only interrupt states where nothing is
   // being played back.
   assign confirm_allowed = (state == IDLE) || (state == ESPERA_RESP) || (state == CERTO);

   // Main controller. Every output is a register updated together with the
   // state, so each output change lines up with the state it belongs to
   // and no input reaches an output combinationally. The if/else chain
   // gives zera priority over set_pos, set_pos over tocar_confirma, and
   // tocar_confirma over button presses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         seq_reg      <= '0;
         idx          <= '0;
         cnt          <= '0;
         pronto_play  <= 1'b1;
         acertou_play <= 1'b0;
         errou        <= 1'b0;
         tom_ativo    <= 1'b0;
         nota         <= 2'b00;
      end else begin
         errou <= 1'b0;
         if (zera) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            pronto_play  <= 1'b1;
            acertou_play <= 1'b0;
            tom_ativo    <= 1'b0;
            nota         <= 2'b00;
         end else if (set_pos) begin
            state        <= LOAD;
            seq_reg      <= seq_data;
            idx          <= '0;
            cnt          <= '0;
            pronto_play  <= 1'b0;
            acertou_play <= 1'b0;
            tom_ativo    <= 1'b0;
            nota         <= 2'b00;
         end else if (tocar_confirma && confirm_allowed) begin
            state       <= CONFIRMA;
            cnt         <= '0;
            pronto_play <= 1'b0;
            tom_ativo   <= 1'b1;
            nota        <= 2'b00;
         end else begin
            case (state)
               IDLE: begin
               end

               LOAD: begin
                  state     <= TOCA;
                  idx       <= '0;
                  cnt       <= '0;
                  tom_ativo <= 1'b1;
                  nota      <= seq_reg[1:0];
               end

               TOCA: begin
                  if (cnt == NOTE_LAST) begin
                     state     <= PAUSA;
                     cnt       <= '0;
                     tom_ativo <= 1'b0;
                     nota      <= 2'b00;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               // After the gap of the last note the index is rewound so it
               // can be reused as the response position.
               PAUSA: begin
                  if (cnt == GAP_LAST) begin
                     cnt <= '0;
                     if (idx == IDX_LAST) begin
                        state       <= ESPERA_RESP;
                        idx         <= '0;
                        pronto_play <= 1'b1;
                     end else begin
                        state     <= TOCA;
                        idx       <= idx_next;
                        tom_ativo <= 1'b1;
                        nota      <= next_note;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               // A wrong press replays the whole sequence from note 0, so
               // the first note is loaded straight into the tone outputs.
               ESPERA_RESP: begin
                  if (jogando && (botoes != 4'b0000)) begin
                     if (botoes == expected_press) begin
                        if (idx == IDX_LAST) begin
                           state        <= CERTO;
                           idx          <= '0;
                           acertou_play <= 1'b1;
                        end else begin
                           idx <= idx_next;
                        end
                     end else begin
                        state       <= TOCA;
                        errou       <= 1'b1;
                        idx         <= '0;
                        cnt         <= '0;
                        pronto_play <= 1'b0;
                        tom_ativo   <= 1'b1;
                        nota        <= seq_reg[1:0];
                     end
                  end
               end

               CERTO: begin
               end

               CONFIRMA: begin
                  if (cnt == CONFIRM_LAST) begin
                     state        <= IDLE;
                     cnt          <= '0;
                     pronto_play  <= 1'b1;
                     acertou_play <= 1'b0;
                     tom_ativo    <= 1'b0;
                     nota         <= 2'b00;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               default: begin
                  state        <= IDLE;
                  idx          <= '0;
                  cnt          <= '0;
                  pronto_play  <= 1'b1;
                  acertou_play <= 1'b0;
                  tom_ativo    <= 1'b0;
                  nota         <= 2'b00;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_neurosync_play_unit.sv
// ---------------------------------------------------------------------------
// tb_neurosync_play_unit
//
// Directed bench for neurosync_play_unit with small timing parameters.
// Expected output words {pronto, acertou, errou, tom, nota} are queued as
// each step is driven and popped one per clock when the outputs are
// sampled, 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_neurosync_play_unit;

   localparam int SEQ_LEN        = 4;
   localparam int NOTE_CYCLES    = 4;
   localparam int GAP_CYCLES     = 2;
   localparam int CONFIRM_CYCLES = 3;

   // Output words: {pronto, acertou, errou, tom_ativo, nota[1:0]}
   localparam logic [5:0] W_IDLE      = 6'b100000;
   localparam logic [5:0] W_LOAD      = 6'b000000;
   localparam logic [5:0] W_CERTO     = 6'b110000;
   localparam logic [5:0] W_CONF_WIN  = 6'b010100;
   localparam logic [5:0] W_CONF      = 6'b000100;

   logic                 clock;
   logic                 reset;
   logic                 zera;
   logic                 set_pos;
   logic [2*SEQ_LEN-1:0] seq_data;
   logic                 jogando;
   logic [3:0]           botoes;
   logic                 tocar_confirma;
   logic                 pronto_play;
   logic                 acertou_play;
   logic                 errou;
   logic                 tom_ativo;
   logic [1:0]           nota;

   typedef struct {
      string      tag;
      logic [5:0] word;
   } exp_t;

   exp_t expQ[$];
   int   assertCount;
   int   failCount;

   neurosync_play_unit #(
      .SEQ_LEN(SEQ_LEN),
      .NOTE_CYCLES(NOTE_CYCLES),
      .GAP_CYCLES(GAP_CYCLES),
      .CONFIRM_CYCLES(CONFIRM_CYCLES)
   ) dut (
      .clock(clock),
      .reset(reset),
      .zera(zera),
      .set_pos(set_pos),
      .seq_data(seq_data),
      .jogando(jogando),
      .botoes(botoes),
      .tocar_confirma(tocar_confirma),
      .pronto_play(pronto_play),
      .acertou_play(acertou_play),
      .errou(errou),
      .tom_ativo(tom_ativo),
      .nota(nota)
   );

   // 10-unit clock period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic pushExp(input string tag, input logic [5:0] word);
      exp_t e;
      e.tag  = tag;
      e.word = word;
      expQ.push_back(e);
   endtask

   // Queue the first n cycles of a playback: each note sounds for
   // NOTE_CYCLES cycles followed by GAP_CYCLES silent ones. When withErrou
   // is set the first cycle also carries the wrong-press pulse.
   task automatic pushPlayback(input string tag, input logic [7:0] seq,
                               input logic withErrou, input int n);
      int   pushed;
      logic [1:0] note;
      pushed = 0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         note = seq[2*i +: 2];
         for (int c = 0; c < NOTE_CYCLES; c++) begin
            if (pushed < n) begin
               pushExp($sformatf("%s_note%0d_c%0d", tag, i, c),
                       {2'b00, (withErrou && i == 0 && c == 0), 1'b1, note});
            end
            pushed++;
         end
         for (int g = 0; g < GAP_CYCLES; g++) begin
            if (pushed < n) begin
               pushExp($sformatf("%s_gap%0d_c%0d", tag, i, g), 6'b000000);
            end
            pushed++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [5:0] obs;
      obs = {pronto_play, acertou_play, errou, tom_ativo, nota};
      assertCount++;
      if (expQ.size() == 0) begin
         failCount++;
         $error("[TB] FAIL no_expectation: observed %b, required a queued expectation", obs);
      end else begin
         e = expQ.pop_front();
         assert (obs === e.word) else begin
            failCount++;
            $error("[TB] FAIL %s: observed {p,a,e,t,n}=%b required %b", e.tag, obs, e.word);
         end
      end
   endtask

   // Drive one cycle of inputs, check the cycle that follows, and drop the
   // pulse inputs again.
   task automatic applyStimulus(input logic sp, input logic tc, input logic z,
                                input logic [3:0] bt);
      set_pos        = sp;
      tocar_confirma = tc;
      zera           = z;
      botoes         = bt;
      tick();
      checkOutput();
      set_pos        = 1'b0;
      tocar_confirma = 1'b0;
      zera           = 1'b0;
      botoes         = 4'b0000;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      end
   endtask

   // Load a sequence and let it play through to the response wait.
   task automatic loadAndPlay(input string tag, input logic [7:0] seq);
      seq_data = seq;
      pushExp({tag, "_load"}, W_LOAD);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      pushPlayback(tag, seq, 1'b0, SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));
      pushExp({tag, "_espera"}, W_IDLE);
      runCycles(SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES) + 1);
   endtask

   // Answer every note correctly; the last press lands in CERTO.
   task automatic answerCorrect(input string tag, input logic [7:0] seq);
      logic [3:0] b;
      for (int i = 0; i < SEQ_LEN; i++) begin
         b = 4'b0001;
         b = b << seq[2*i +: 2];
         pushExp($sformatf("%s_press%0d", tag, i), (i == SEQ_LEN-1) ? W_CERTO : W_IDLE);
         applyStimulus(1'b0, 1'b0, 1'b0, b);
      end
   endtask

   // Confirmation tone: CONFIRM_CYCLES cycles of tone, then IDLE.
   task automatic confirmTone(input string tag, input logic [5:0] toneWord);
      for (int i = 0; i < CONFIRM_CYCLES; i++) begin
         pushExp($sformatf("%s_tone%0d", tag, i), toneWord);
      end
      pushExp({tag, "_idle"}, W_IDLE);
   endtask

   initial begin
      assertCount    = 0;
      failCount      = 0;
      reset          = 1'b1;
      zera           = 1'b0;
      set_pos        = 1'b0;
      seq_data       = 8'h00;
      jogando        = 1'b0;
      botoes         = 4'b0000;
      tocar_confirma = 1'b0;

      // Reset values while reset is held.
      #3;
      pushExp("reset_state", W_IDLE);
      checkOutput();
      tick();
      reset = 1'b0;
      pushExp("idle0", W_IDLE);
      pushExp("idle1", W_IDLE);
      runCycles(2);

      // Full playback of 0,1,2,3; pronto_play returns 26 cycles after set_pos.
      jogando = 1'b1;
      loadAndPlay("play1", 8'hE4);

      // Correct answers reach CERTO; presses in CERTO are ignored.
      answerCorrect("ok1", 8'hE4);
      pushExp("certo_hold", W_CERTO);
      runCycles(1);
      pushExp("certo_press_ignored", W_CERTO);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);

      // Confirmation from CERTO keeps acertou until the tone ends.
      confirmTone("conf1", W_CONF_WIN);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
      runCycles(CONFIRM_CYCLES);

      // One correct press, then a wrong one: errou pulse and full replay.
      loadAndPlay("play2", 8'hE4);
      pushExp("p2_press0", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      pushPlayback("replay2", 8'hE4, 1'b1, SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));
      pushExp("replay2_espera", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
      runCycles(SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));
      answerCorrect("ok2", 8'hE4);
      confirmTone("conf2", W_CONF_WIN);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
      runCycles(CONFIRM_CYCLES);

      // Presses with jogando low are ignored; a multi-bit press is wrong.
      loadAndPlay("play3", 8'hE4);
      jogando = 1'b0;
      pushExp("nojog_wrong", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010);
      pushExp("nojog_right", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      jogando = 1'b1;
      pushExp("jog_first", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      pushPlayback("replay3", 8'hE4, 1'b1, SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));
      pushExp("replay3_espera", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0011);
      runCycles(SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));

      // tocar_confirma outranks a simultaneous wrong press in ESPERA_RESP.
      confirmTone("conf3", W_CONF);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100);
      runCycles(CONFIRM_CYCLES);

      // tocar_confirma ignored during TOCA; zera during note 2 goes to IDLE.
      seq_data = 8'hE4;
      pushExp("play4_load", W_LOAD);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      pushPlayback("play4", 8'hE4, 1'b0, 2*(NOTE_CYCLES+GAP_CYCLES) + 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
      runCycles(2*(NOTE_CYCLES+GAP_CYCLES) + 1);
      pushExp("zera_idle", W_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
      pushExp("zera_idle1", W_IDLE);
      pushExp("zera_idle2", W_IDLE);
      runCycles(2);

      // set_pos during the first gap restarts with the new sequence.
      pushExp("play5_load", W_LOAD);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      pushPlayback("play5", 8'hE4, 1'b0, NOTE_CYCLES + 1);
      runCycles(NOTE_CYCLES + 1);
      loadAndPlay("playFF", 8'hFF);

      // A press coinciding with set_pos is dropped (no errou).
      seq_data = 8'hFF;
      pushExp("press_with_setpos", W_LOAD);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001);
      pushPlayback("playFF2", 8'hFF, 1'b0, SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES));
      pushExp("playFF2_espera", W_IDLE);
      runCycles(SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES) + 1);
      answerCorrect("okFF", 8'hFF);

      // Every queued expectation must have been consumed.
      assertCount++;
      assert (expQ.size() === 0) else begin
         failCount++;
         $error("[TB] FAIL queue_drained: observed %0d leftover entries, required 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
